// File: rtl/apb_master_if.sv
`default_nettype none
// ============================================================================
// Module   : apb_master_if
// Purpose  : Command/response and APB requester signal bundle for apb_master.
// Revision : 1.0  initial release
// ============================================================================
interface apb_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Command channel
  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic                  cmd_write_i;
  logic [ADDR_W-1:0]     cmd_addr_i;
  logic [DATA_W-1:0]     cmd_wdata_i;
  logic [DATA_W/8-1:0]   cmd_strb_i;

  // Response channel
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [DATA_W-1:0]     rsp_rdata_o;
  logic                  rsp_slverr_o;

  // APB requester side
  logic [ADDR_W-1:0]     paddr_o;
  logic                  psel_o;
  logic                  penable_o;
  logic                  pwrite_o;
  logic [DATA_W-1:0]     pwdata_o;
  logic [DATA_W/8-1:0]   pstrb_o;
  logic                  pready_i;
  logic [DATA_W-1:0]     prdata_i;
  logic                  pslverr_i;

  modport master (
    input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i,
    input  rsp_ready_i,
    input  pready_i, prdata_i, pslverr_i,
    output cmd_ready_o,
    output rsp_valid_o, rsp_rdata_o, rsp_slverr_o,
    output paddr_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o
  );

  modport slave (
    output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_strb_i,
    output rsp_ready_i,
    output pready_i, prdata_i, pslverr_i,
    input  cmd_ready_o,
    input  rsp_valid_o, rsp_rdata_o, rsp_slverr_o,
    input  paddr_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o
  );
endinterface
`default_nettype wire

// File: rtl/apb_master.sv
`default_nettype none
// ============================================================================
// Module   : apb_master
// Purpose  : Single-outstanding command-to-APB bridge (IDLE/SETUP/ACCESS/RESP).
//            Define APB_MASTER_TIMEOUT_EN to add the ACCESS-phase watchdog.
// Revision : 1.0  initial release
// ============================================================================
module apb_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  wire logic        clk_i,
  input  wire logic        rst_i,
  apb_master_if.master     bus
);

  localparam int c_STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_cmd_ready;
  logic [ADDR_W-1:0]     r_paddr;
  logic                  r_pwrite;
  logic [DATA_W-1:0]     r_pwdata;
  logic [c_STRB_W-1:0]   r_pstrb;
  logic [DATA_W-1:0]     r_rsp_rdata;
  logic                  r_rsp_slverr;

  logic                  w_accept;
  logic                  w_done;
  logic                  w_timeout;

  if ((DATA_W % 8 != 0) || (TIMEOUT_CYCLES < 1)) begin : g_bad_param
    $error("apb_master: DATA_W must be a multiple of 8 and TIMEOUT_CYCLES >= 1");
  end

  assign w_accept = bus.cmd_valid_i && r_cmd_ready;
  assign w_done   = (r_state == S_ACCESS) && bus.pready_i;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int                 c_CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [c_CNT_W-1:0] r_wd_cnt;

  // Counts completed wait cycles; the last one times out unless pready_i wins.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wd_cnt <= '0;
    end else if (r_state == S_SETUP) begin
      r_wd_cnt <= '0;
    end else if ((r_state == S_ACCESS) && !bus.pready_i) begin
      r_wd_cnt <= r_wd_cnt + c_CNT_W'(1);
    end
  end

  assign w_timeout = (r_state == S_ACCESS) && !bus.pready_i && (r_wd_cnt == c_CNT_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = S_SETUP;
      S_SETUP:  w_state_nxt = S_ACCESS;
      S_ACCESS: if (w_done || w_timeout) w_state_nxt = S_RESP;
      S_RESP:   if (bus.rsp_ready_i) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Registered from next state so ready stays low for the whole reset pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cmd_ready <= 1'b0;
    end else begin
      r_cmd_ready <= (w_state_nxt == S_IDLE);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_paddr  <= '0;
      r_pwrite <= 1'b0;
      r_pwdata <= '0;
      r_pstrb  <= '0;
    end else if (w_accept) begin
      r_paddr  <= bus.cmd_addr_i;
      r_pwrite <= bus.cmd_write_i;
      r_pwdata <= bus.cmd_write_i ? bus.cmd_wdata_i : '0;
      r_pstrb  <= bus.cmd_write_i ? bus.cmd_strb_i  : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rsp_rdata  <= '0;
      r_rsp_slverr <= 1'b0;
    end else if (w_done) begin
      r_rsp_rdata  <= r_pwrite ? '0 : bus.prdata_i;
      r_rsp_slverr <= bus.pslverr_i;
    end else if (w_timeout) begin
      r_rsp_rdata  <= '0;
      r_rsp_slverr <= 1'b1;
    end
  end

  assign bus.cmd_ready_o  = r_cmd_ready;
  assign bus.psel_o       = (r_state == S_SETUP) || (r_state == S_ACCESS);
  assign bus.penable_o    = (r_state == S_ACCESS);
  assign bus.paddr_o      = r_paddr;
  assign bus.pwrite_o     = r_pwrite;
  assign bus.pwdata_o     = r_pwdata;
  assign bus.pstrb_o      = r_pstrb;
  assign bus.rsp_valid_o  = (r_state == S_RESP);
  assign bus.rsp_rdata_o  = r_rsp_rdata;
  assign bus.rsp_slverr_o = r_rsp_slverr;

endmodule
`default_nettype wire
